// File: rtl/prog_loader.sv
// Host-link image loader: receives a length-prefixed byte frame and writes it as
// 64-bit little-endian words into IM/DM, holding the CPU in reset until done.
module prog_loader #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  output logic              cpu_rst,
  output logic              load_done
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, WRITE, DONE} state_t;

  state_t            r_state, w_state_next;
  logic [15:0]       r_len, w_len_next;
  logic [15:0]       r_count, w_count_next;
  logic [3:0]        r_offset, w_offset_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [63:0]       r_wdata, w_wdata_next;
  logic [7:0]        r_wstrb, w_wstrb_next;
  logic              r_s_ready, r_mem_we, r_cpu_rst, r_load_done;
  logic              w_xfer;

  assign w_xfer = s_valid & r_s_ready;

  always_comb begin
    w_state_next  = r_state;
    w_len_next    = r_len;
    w_count_next  = r_count;
    w_offset_next = r_offset;
    w_addr_next   = r_addr;
    w_wdata_next  = r_wdata;
    w_wstrb_next  = r_wstrb;
    case (r_state)
      LEN0: begin
        if (w_xfer) begin
          w_len_next[7:0] = s_data;
          w_state_next    = LEN1;
        end
      end
      LEN1: begin
        if (w_xfer) begin
          w_len_next[15:8] = s_data;
          if ({s_data, r_len[7:0]} == 16'd0) begin
            w_state_next = DONE;
          end else begin
            w_addr_next   = BASE_ADDR;
            w_offset_next = 4'd0;
            w_count_next  = 16'd0;
            w_wdata_next  = '0;
            w_wstrb_next  = '0;
            w_state_next  = DATA;
          end
        end
      end
      DATA: begin
        if (w_xfer) begin
          w_wdata_next[{r_offset[2:0], 3'b000} +: 8] = s_data;
          w_wstrb_next[r_offset[2:0]]                = 1'b1;
          w_offset_next = r_offset + 4'd1;
          w_count_next  = r_count + 16'd1;
          // Flush on a full word or on the last payload byte (partial word).
          if (w_offset_next == 4'd8 || w_count_next == r_len) begin
            w_state_next = WRITE;
          end
        end
      end
      WRITE: begin
        if (r_count == r_len) begin
          w_state_next = DONE;
        end else begin
          w_addr_next   = r_addr + ADDR_W'(8);
          w_offset_next = 4'd0;
          w_wdata_next  = '0;
          w_wstrb_next  = '0;
          w_state_next  = DATA;
        end
      end
      DONE: begin
        w_state_next = DONE;
      end
      default: begin
        w_state_next = LEN0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= LEN0;
      r_len       <= '0;
      r_count     <= '0;
      r_offset    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_s_ready   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_load_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_len       <= w_len_next;
      r_count     <= w_count_next;
      r_offset    <= w_offset_next;
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_wstrb     <= w_wstrb_next;
      // Ready and write-enable track the state being entered, so they line up with it.
      r_s_ready   <= (w_state_next == LEN0) || (w_state_next == LEN1) || (w_state_next == DATA);
      r_mem_we    <= (w_state_next == WRITE);
      r_cpu_rst   <= (r_state != DONE);
      r_load_done <= (r_state == DONE);
    end
  end

  assign s_ready   = r_s_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign cpu_rst   = r_cpu_rst;
  assign load_done = r_load_done;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Hardware counterpart of the bench-side hex preload: accepts a byte stream over a valid/ready interface and writes it into the instruction and data memories.
- Writes are 64-bit and little-endian; each byte goes to the same byte address in both IM and DM.
- Holds the CPU in reset until the image is fully written, then releases it so execution starts from PC 0.
- Sits between an external host link (UART/JTAG bridge) and the Top memory write ports.

Parameters:
- ADDR_W, 16, byte-address width of the memory write port; load addresses wrap modulo 2^ADDR_W.
- BASE_ADDR, 0, byte address of the first payload byte; must be 8-byte aligned.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input byte valid
- s_data  in  8  input byte
- s_ready  out  1  loader accepts byte this cycle (transfer = s_valid & s_ready)
- mem_we  out  1  one-cycle write pulse to IM and DM
- mem_addr  out  ADDR_W  8-byte-aligned byte address of the word being written
- mem_wdata  out  64  word data; byte k belongs at mem_addr+k
- mem_wstrb  out  8  byte enables; bit k qualifies mem_wdata[8k+7:8k]
- cpu_rst  out  1  active-high reset to the CPU; high until load complete
- load_done  out  1  high once the whole image is written; sticky until rst

Behaviour:
- Reset (async, rst=1) forces: state=LEN0, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, cpu_rst=1, load_done=0, byte counter=0, word offset=0.
- s_ready is a registered output:
  - 1 in LEN0, LEN1 and DATA.
  - 0 in WRITE and DONE.
  - 0 during reset and in the first cycle after reset deassertion, when s_ready is still 0 from reset; it reaches 1 on the next edge.
- Frame format: LEN_LO byte, LEN_HI byte (16-bit payload byte count N, little-endian), then N payload bytes.
- FSM:
  - LEN0: on transfer, capture LEN_LO, go to LEN1.
  - LEN1: on transfer, capture LEN_HI.
    - N==0: go straight to DONE; no write is issued.
    - Otherwise: set word address to BASE_ADDR, offset to 0, clear wdata and wstrb, go to DATA.
  - DATA: on transfer, place the byte in lane=offset, set wstrb[offset], increment offset and the received count.
    - If offset reaches 8 or the received count reaches N, go to WRITE.
    - Otherwise stay in DATA.
  - WRITE: single cycle; mem_we=1 with the current mem_addr/mem_wdata/mem_wstrb. Next cycle mem_we=0.
    - If received count == N, go to DONE.
    - Otherwise add 8 to mem_addr (mod 2^ADDR_W), clear offset, wdata and wstrb, and return to DATA.
  - DONE: cpu_rst=0 and load_done=1 (registered, asserted the cycle after entry). Stays there and ignores s_valid until rst.
- Partial final word: only the received lanes are strobed; unstrobed lanes of mem_wdata are 0.
- Backpressure: s_valid may stay high with no transfer while s_ready=0; the held byte is accepted once s_ready returns to 1, with no loss or duplication.
- s_valid low in any state means no state change (idle cycles are legal anywhere).
- Throughput: a full word takes 8 accepting cycles plus 1 WRITE cycle.
- rst asserted mid-load aborts immediately to reset values. cpu_rst goes back to 1 and any partially collected word is discarded (not written). The host must resend the whole frame.
- Counter widths: received count is 16 bits; offset is 4 bits (0..8).

Test Plan:
1. Send 0x10,0x00 then bytes 0x00..0x0F → two writes:
   - mem_addr=0x0000, wdata=0x0706050403020100, wstrb=0xFF
   - mem_addr=0x0008, wdata=0x0F0E0D0C0B0A0908, wstrb=0xFF
   - then load_done=1 and cpu_rst=0.
2. Send N=3, bytes 0xAA,0xBB,0xCC → one write at 0x0000, wdata=0x0000000000CCBBAA, wstrb=0x07; cpu_rst falls after the write.
3. Send N=0 → no mem_we pulse; load_done=1 and cpu_rst=0 two cycles after the LEN_HI transfer.
4. Hold s_valid=1 with an incrementing byte on each transfer across a word boundary (N=9) → s_ready=0 exactly in the WRITE cycle and the held byte 0x08 lands in lane 0 of the second word (addr 0x0008, wstrb=0x01); no byte dropped or duplicated.
5. Assert rst after 5 payload bytes of N=16 → no mem_we for that partial word. Then resend the full frame → results identical to scenario 1.
6. BASE_ADDR=0xFFF8, ADDR_W=16, N=16 → writes at 0xFFF8 then 0x0000 (wrap).
